// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit: widths,
// LSU funct3 encodings, FSM state type and the alignment legality rule.
package mem_access_unit_pkg;

  localparam int unsigned DEF_ARCH_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_t;

  // size is funct3[1:0]; size 2'b11 is never a legal access
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: selects the addressed byte/half of the bus word and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    case (funct3)
      FUNCT3_B:  data = {{24{byte_v[7]}}, byte_v};
      FUNCT3_H:  data = {{16{half_v[15]}}, half_v};
      FUNCT3_BU: data = {24'd0, byte_v};
      FUNCT3_HU: data = {16'd0, half_v};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/gnt/rvalid bus handshake,
// store lane steering, load alignment, pipeline stall, timeout and flush handling.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ARCH_WIDTH = DEF_ARCH_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            mem_funct3,
  input  logic [ARCH_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ARCH_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] mem_data_mem_out,
  output logic                  mem_stall,
  output logic                  mem_done,
  output logic                  mem_misaligned,
  output logic                  mem_bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  mem_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   discard_q, discard_d;
  logic                   err_q, err_d;
  logic                   load_en;
  logic [ARCH_WIDTH-1:0]  addr_q;
  logic                   we_q;
  logic [3:0]             be_q, be_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [2:0]             funct3_q;
  logic [DATA_WIDTH-1:0]  data_q, aligned;
  logic                   new_access, misaligned, start, timeout_hit;

  assign new_access  = mem_valid & (mem_read | mem_write) & ~flush;
  assign misaligned  = is_misaligned(mem_funct3[1:0], mem_addr[1:0]);
  assign start       = (state_q == MEM_IDLE) & new_access & ~misaligned;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = mem_wdata;
    case (mem_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << mem_addr[1:0];
        wdata_d = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  mem_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data    (aligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MEM_IDLE;
    else      state_q <= state_d;
  end

  // Discard is the OR of the stored flag and a same-cycle flush, so a flush
  // landing together with rvalid or timeout already suppresses the result.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    err_d     = 1'b0;
    load_en   = 1'b0;
    case (state_q)
      MEM_IDLE: if (start) state_d = MEM_REQ;
      MEM_REQ: begin
        if (dmem_gnt) begin
          if (we_q) state_d = flush ? MEM_IDLE : MEM_DONE;
          else begin
            state_d   = MEM_WAIT;
            discard_d = flush;
          end
        end else if (flush) begin
          state_d = MEM_IDLE;
        end else if (timeout_hit) begin
          state_d = MEM_DONE;
          err_d   = 1'b1;
        end
      end
      MEM_WAIT: begin
        discard_d = discard_q | flush;
        if (dmem_rvalid) begin
          state_d = discard_d ? MEM_IDLE : MEM_DONE;
          load_en = ~discard_d;
        end else if (timeout_hit) begin
          state_d = discard_d ? MEM_IDLE : MEM_DONE;
          err_d   = ~discard_d;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
    if (state_d == MEM_IDLE) discard_d = 1'b0;
  end

  always_comb begin
    dmem_req       = 1'b0;
    mem_stall      = 1'b0;
    mem_done       = 1'b0;
    mem_misaligned = 1'b0;
    mem_bus_err    = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (new_access) begin
          mem_misaligned = misaligned;
          mem_done       = misaligned;
          mem_stall      = ~misaligned;
        end
      end
      MEM_REQ: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
      end
      MEM_WAIT: mem_stall = 1'b1;
      MEM_DONE: begin
        mem_done    = 1'b1;
        mem_bus_err = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      data_q    <= '0;
    end else begin
      discard_q <= discard_d;
      err_q     <= err_d;
      if (state_d == MEM_IDLE)
        cnt_q <= '0;
      else if ((state_q == MEM_REQ) || (state_q == MEM_WAIT))
        cnt_q <= cnt_q + 1'b1;
      if (start) begin
        addr_q   <= mem_addr;
        we_q     <= mem_write;
        be_q     <= be_d;
        wdata_q  <= wdata_d;
        funct3_q <= mem_funct3;
      end
      if (load_en)    data_q <= aligned;
      else if (err_d) data_q <= '0;
    end
  end

  assign dmem_we          = we_q;
  assign dmem_addr        = {addr_q[ARCH_WIDTH-1:2], 2'b00};
  assign dmem_be          = be_q;
  assign dmem_wdata       = wdata_q;
  assign mem_data_mem_out = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses, each judged against per-transaction expectations computed from the rules.
module tb_mem_access_unit;

  localparam int unsigned T    = 8;
  localparam int          NCYC = T + 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, mem_valid, mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata, mem_data_mem_out;
  logic        mem_stall, mem_done, mem_misaligned, mem_bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_data = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.ARCH_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_data_mem_out(mem_data_mem_out), .mem_stall(mem_stall), .mem_done(mem_done),
    .mem_misaligned(mem_misaligned), .mem_bus_err(mem_bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; mem_valid = 0; mem_read = 0; mem_write = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 32'd0;
  endtask

  // fmode: 0 none, 1 flush in first WAIT cycle, 2 flush in first REQ cycle, 3 flush with the request
  task automatic run_txn(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rdl,
                         input logic [31:0] rdat, input int fmode, input string tag);
    int sz, gc, rc, fc;
    logic mis;
    logic [31:0] exp_be, exp_wd, v, data_next;
    int exp_req, exp_stall, exp_done, exp_err, exp_mis;
    int n_req, n_stall, n_done, n_err, n_mis, lane_bad;
    sz  = int'(f3[1:0]);
    mis = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    exp_be = (sz == 0) ? (32'd1 << a[1:0]) : (sz == 1) ? (32'd3 << a[1:0]) : 32'd15;
    exp_wd = (sz == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
             (sz == 1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    if (sz == 0) begin
      v = (rdat >> (8 * a[1:0])) & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 1) begin
      v = (rdat >> (16 * a[1])) & 32'hFFFF;
      if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
    end else v = rdat;
    gc = (gd < int'(T)) ? 1 + gd : -1;
    rc = (gc >= 0 && rd) ? gc + 1 + rdl : -1;
    fc = (fmode == 1) ? gc + 1 : (fmode == 2) ? 1 : (fmode == 3) ? 0 : -1;

    data_next = model_data;
    exp_req = 0; exp_stall = 0; exp_done = 0; exp_err = 0; exp_mis = 0;
    if (fmode == 3) begin
    end else if (mis) begin
      exp_mis = 1; exp_done = 1;
    end else if (fmode == 2) begin
      exp_req = 1; exp_stall = 2;
    end else if (gd >= int'(T)) begin
      exp_req = T; exp_stall = 1 + T; exp_done = 1; exp_err = 1; data_next = 32'd0;
    end else if (!rd) begin
      exp_req = gd + 1; exp_stall = gd + 2; exp_done = 1;
    end else begin
      exp_req = gd + 1;
      if (gd + rdl + 2 > int'(T)) begin
        exp_stall = 1 + T;
        if (fmode != 1) begin exp_done = 1; exp_err = 1; data_next = 32'd0; end
      end else begin
        exp_stall = gd + rdl + 3;
        if (fmode != 1) begin exp_done = 1; data_next = v; end
      end
    end

    n_req = 0; n_stall = 0; n_done = 0; n_err = 0; n_mis = 0; lane_bad = 0;
    for (int c = 0; c < NCYC; c++) begin
      mem_valid   = (c == 0);
      mem_read    = (c == 0) && rd;
      mem_write   = (c == 0) && !rd;
      mem_funct3  = f3;
      mem_addr    = a;
      mem_wdata   = wd;
      flush       = (c == fc);
      dmem_gnt    = (c == gc);
      dmem_rvalid = (c == rc);
      dmem_rdata  = (c == rc) ? rdat : $urandom;
      #1;
      if (dmem_req) begin
        n_req++;
        if (dmem_addr !== {a[31:2], 2'b00} || dmem_be !== exp_be[3:0] ||
            dmem_we !== !rd || (!rd && dmem_wdata !== exp_wd)) lane_bad++;
      end
      n_stall += int'(mem_stall);
      n_done  += int'(mem_done);
      n_err   += int'(mem_bus_err);
      n_mis   += int'(mem_misaligned);
      @(posedge clk); #1;
    end
    idle_inputs();
    check({tag, ".req_cycles"},   n_req,    exp_req);
    check({tag, ".stall_cycles"}, n_stall,  exp_stall);
    check({tag, ".done"},         n_done,   exp_done);
    check({tag, ".bus_err"},      n_err,    exp_err);
    check({tag, ".misaligned"},   n_mis,    exp_mis);
    check({tag, ".lanes"},        lane_bad, 0);
    check({tag, ".data"},         mem_data_mem_out, data_next);
    model_data = data_next;
  endtask

  initial begin
    logic rd;
    logic [2:0] f3;
    logic [31:0] a;
    int gd, rdl, fm;
    rst = 1'b0;
    mem_funct3 = 3'b000; mem_addr = 32'd0; mem_wdata = 32'd0;
    idle_inputs();
    #1;
    check("reset.req",   dmem_req,         0);
    check("reset.stall", mem_stall,        0);
    check("reset.done",  mem_done,         0);
    check("reset.data",  mem_data_mem_out, 0);
    check("reset.be",    dmem_be,          0);
    check("reset.addr",  dmem_addr,        0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b1, 3'b000, 32'h0000_1003, 32'd0,          0, 0, 32'h80FF_0000, 0, "lb");
    run_txn(1'b0, 3'b001, 32'h0000_2002, 32'h1234_ABCD,  3, 0, 32'd0,         0, "sh");
    run_txn(1'b1, 3'b010, 32'h0000_3001, 32'd0,          0, 0, 32'd0,         0, "lw_mis");
    run_txn(1'b1, 3'b101, 32'h0000_0040, 32'd0,          T, 0, 32'd0,         0, "lhu_timeout");
    run_txn(1'b1, 3'b010, 32'h0000_0044, 32'd0,          1, 1, 32'h1357_9BDF, 0, "lw");
    run_txn(1'b1, 3'b010, 32'h0000_0048, 32'd0,          0, 2, 32'hDEAD_BEEF, 1, "lw_flush_wait");
    run_txn(1'b0, 3'b000, 32'h0000_0049, 32'h0000_00A5,  2, 0, 32'd0,         2, "sb_flush_req");
    run_txn(1'b1, 3'b010, 32'h0000_004C, 32'd0,          0, 0, 32'h0BAD_F00D, 3, "lw_flush_idle");

    mem_valid = 1; mem_read = 1; mem_funct3 = 3'b010; mem_addr = 32'h50;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("rst_mid.req_before", dmem_req, 1);
    rst = 1'b0;
    #1;
    check("rst_mid.req_async", dmem_req,  0);
    check("rst_mid.stall",     mem_stall, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_rvalid = 1; dmem_rdata = 32'h5555_5555;
    #1;
    check("rst_mid.stray_done",  mem_done,  0);
    check("rst_mid.stray_stall", mem_stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    model_data = 32'd0;
    check("rst_mid.data", mem_data_mem_out, model_data);

    for (int i = 0; i < 40; i++) begin
      rd  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = {20'd0, 10'($urandom), 2'($urandom)};
      gd  = $urandom_range(0, T + 1);
      rdl = $urandom_range(0, 5);
      fm  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (fm == 1 && (!rd || gd >= int'(T) || rdl == 0)) fm = 0;
      if (fm == 2 && gd == 0) fm = 0;
      run_txn(rd, f3, a, $urandom, gd, rdl, $urandom, fm, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
